// File: rtl/bram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_reader_pkg
// Description : Shared types and constants for the BRAM stream reader.
//               - reader_state_t       : command FSM state encoding
//               - c_FIFO_DEPTH_DEFAULT : default output FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  localparam int c_FIFO_DEPTH_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_if
// Description : Bundles the command, RAM-port and output-stream signals of
//               the BRAM stream reader.
//   Command : start, base_addr, length  -> reader ; busy, done <- reader
//   RAM port: ram_addr, ram_en, ram_regce <- reader ; ram_dout -> reader
//   Stream  : m_data, m_valid <- reader ; m_ready -> reader
//   modport master : the reader itself
//   modport slave  : the environment (command source, RAM, consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int LEN_W  = $clog2(RAM_DEPTH + 1);

  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [LEN_W-1:0]     length;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    ram_addr;
  logic                 ram_en;
  logic                 ram_regce;
  logic [RAM_WIDTH-1:0] ram_dout;
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    input  start, base_addr, length, ram_dout, m_ready,
    output busy, done, ram_addr, ram_en, ram_regce, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, ram_dout, m_ready,
    input  busy, done, ram_addr, ram_en, ram_regce, m_data, m_valid
  );

endinterface
`default_nettype wire

// File: rtl/bram_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_reader_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
//   clka, rstb : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push (dropped if full and not popping the same cycle)
//   rd_en      : pop the head word (ignored when empty)
//   rd_data    : current head word, valid whenever !empty
//   empty, count : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module bram_reader_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clka,
  input  logic                         rstb,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  assign w_rd = rd_en && (r_count != '0);
  assign w_wr = wr_en && ((r_count != c_FULL) || w_rd);

  always_ff @(posedge clka) begin
    if (rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge clka) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads `length` consecutive words from one port of a
//               single-clock BRAM and presents them as a valid/ready stream.
//               A credit check against an output FIFO hides the RAM read
//               latency and absorbs consumer backpressure.
//   clka, rstb : clock (shared with RAM), synchronous active-high reset
//   bus        : command (start/base_addr/length/busy/done), RAM port
//                (ram_addr/ram_en/ram_regce/ram_dout) and output stream
//                (m_data/m_valid/m_ready)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = c_FIFO_DEPTH_DEFAULT
) (
  input  logic                 clka,
  input  logic                 rstb,
  bram_stream_reader_if.master bus
);
  localparam int                 c_ADDR_W    = $clog2(RAM_DEPTH);
  localparam int                 c_LEN_W     = $clog2(RAM_DEPTH + 1);
  localparam int                 c_CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(RAM_DEPTH - 1);

  reader_state_t             r_state;
  reader_state_t             w_state_nxt;
  logic [c_ADDR_W-1:0]       r_next_addr;   // address of the next read to issue
  logic [c_ADDR_W-1:0]       r_last_addr;   // address presented while idle/stalled
  logic [c_LEN_W-1:0]        r_remaining;
  logic [READ_LATENCY-1:0]   r_vld_sr;      // bit 0 = newest issue
  logic                      r_done;
  logic                      w_busy;
  logic                      w_issue;
  logic                      w_credit;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_last_pop;
  logic                      w_cmd_start;
  logic                      w_zero_start;
  logic                      w_fifo_empty;
  logic [c_CNT_W-1:0]        w_fifo_count;
  int                        w_occupancy;

  // Words already owned by the reader: queued in the FIFO plus still in the
  // RAM pipeline. Issuing only below FIFO_DEPTH guarantees every returning
  // word has a FIFO slot.
  always_comb begin
    w_occupancy = int'(w_fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_occupancy = w_occupancy + int'(r_vld_sr[i]);
    end
  end

  assign w_credit     = (w_occupancy < FIFO_DEPTH);
  assign w_cmd_start  = (r_state == IDLE) && bus.start;
  assign w_zero_start = w_cmd_start && (bus.length == '0);
  assign w_pop        = bus.m_valid && bus.m_ready;
  assign w_push       = r_vld_sr[READ_LATENCY-1];
  // Final handshake: everything issued, nothing in flight, last word popping.
  assign w_last_pop   = (r_state == DRAIN) && w_pop && (r_vld_sr == '0) &&
                        (w_fifo_count == c_CNT_W'(1));

  // ---- FSM: state register ----
  always_ff @(posedge clka) begin
    if (rstb) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_start && !w_zero_start)               w_state_nxt = ISSUE;
      ISSUE:   if (w_issue && (r_remaining == c_LEN_W'(1)))    w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pop)                                 w_state_nxt = IDLE;
      default:                                                 w_state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_busy  = (r_state != IDLE);
    w_issue = (r_state == ISSUE) && (r_remaining != '0) && w_credit;
  end

  // ---- Address / count / done datapath ----
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_zero_start || w_last_pop;
      if (w_cmd_start) begin
        r_next_addr <= bus.base_addr;
        r_remaining <= bus.length;
      end else if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= (r_next_addr == c_ADDR_LAST) ? '0 : r_next_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // ---- Issue-flag shift register tracking reads in the RAM pipeline ----
  generate
    if (READ_LATENCY == 1) begin : g_sr_single
      always_ff @(posedge clka) begin
        if (rstb) r_vld_sr <= '0;
        else      r_vld_sr <= w_issue;
      end
    end else begin : g_sr_multi
      always_ff @(posedge clka) begin
        if (rstb) r_vld_sr <= '0;
        else      r_vld_sr <= {r_vld_sr[READ_LATENCY-2:0], w_issue};
      end
    end
  endgenerate

  bram_reader_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka    (clka),
    .rstb    (rstb),
    .wr_en   (w_push),
    .wr_data (bus.ram_dout),
    .rd_en   (w_pop),
    .rd_data (bus.m_data),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.ram_en    = w_issue;
  // Address moves only on issue cycles, so it holds whenever ram_en is low.
  assign bus.ram_addr  = w_issue ? r_next_addr : r_last_addr;
  assign bus.ram_regce = 1'b1;
  assign bus.m_valid   = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Self-checking bench for bram_stream_reader. Two instances
//               (READ_LATENCY 2 and 1) share one RAM image; `sel` picks the
//               instance being exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;
  localparam int RAM_WIDTH  = 18;
  localparam int RAM_DEPTH  = 1024;
  localparam int FIFO_DEPTH = 4;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  bram_stream_reader_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus2 ();
  bram_stream_reader_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus1 ();

  bram_stream_reader #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH),
                       .READ_LATENCY(2), .FIFO_DEPTH(FIFO_DEPTH))
    dut2 (.clka(clka), .rstb(rstb), .bus(bus2));

  bram_stream_reader #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH),
                       .READ_LATENCY(1), .FIFO_DEPTH(FIFO_DEPTH))
    dut1 (.clka(clka), .rstb(rstb), .bus(bus1));

  // Stimulus
  logic        sel;
  logic        start_d;
  logic [9:0]  base_d;
  logic [10:0] len_d;
  logic        ready_d;

  assign bus2.start     = start_d & ~sel;
  assign bus1.start     = start_d & sel;
  assign bus2.base_addr = base_d;
  assign bus1.base_addr = base_d;
  assign bus2.length    = len_d;
  assign bus1.length    = len_d;
  assign bus2.m_ready   = ready_d;
  assign bus1.m_ready   = ready_d;

  // RAM behaviour: HIGH_PERFORMANCE (latch + output register) and LOW_LATENCY
  logic [17:0] mem [RAM_DEPTH];
  logic [17:0] r2_latch, r2_oreg, r1_latch;
  always @(posedge clka) begin
    if (bus2.ram_en)    r2_latch <= mem[bus2.ram_addr];
    if (bus2.ram_regce) r2_oreg  <= r2_latch;
    if (bus1.ram_en)    r1_latch <= mem[bus1.ram_addr];
  end
  assign bus2.ram_dout = r2_oreg;
  assign bus1.ram_dout = r1_latch;

  // Observation of the selected instance
  wire        o_busy    = sel ? bus1.busy      : bus2.busy;
  wire        o_done    = sel ? bus1.done      : bus2.done;
  wire        o_ram_en  = sel ? bus1.ram_en    : bus2.ram_en;
  wire [9:0]  o_ram_addr= sel ? bus1.ram_addr  : bus2.ram_addr;
  wire        o_regce   = sel ? bus1.ram_regce : bus2.ram_regce;
  wire [17:0] o_m_data  = sel ? bus1.m_data    : bus2.m_data;
  wire        o_m_valid = sel ? bus1.m_valid   : bus2.m_valid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one command on the selected instance and checks it against the
  // reference view: word k of the burst is mem[(base+k) mod RAM_DEPTH].
  task automatic run_burst(input int base, input int len, input int pct,
                           input int restart_at, input int abort_after);
    int          rl, budget, issued, popped, first_valid, last_pop, done_cyc, done_cnt;
    bit          fin, stall;
    logic [17:0] held;
    logic [9:0]  prev_addr;
    rl = sel ? 1 : 2;
    issued = 0; popped = 0; first_valid = -1; last_pop = -1;
    done_cyc = -1; done_cnt = 0; fin = 0; stall = 0; held = '0;
    budget = len * 40 + 40;

    @(posedge clka); #1;
    start_d = 1'b1; base_d = 10'(base); len_d = 11'(len);
    ready_d = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
    @(negedge clka);
    chk("busy_before_start", o_busy, 1'b0);
    prev_addr = o_ram_addr;

    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      @(posedge clka); #1;
      start_d = (cyc == restart_at);
      if (cyc == restart_at) begin
        base_d = 10'($urandom);
        len_d  = 11'($urandom_range(1, RAM_DEPTH));
      end
      ready_d = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      @(negedge clka);

      if (o_ram_en) begin
        chk("issue_count", issued < len, 1'b1);
        chk("ram_addr", o_ram_addr, (base + issued) % RAM_DEPTH);
        issued++;
        chk("credit_limit", (issued - popped) <= FIFO_DEPTH, 1'b1);
      end else begin
        chk("ram_addr_hold", o_ram_addr, prev_addr);
      end
      prev_addr = o_ram_addr;

      if (stall) begin
        chk("hold_valid", o_m_valid, 1'b1);
        chk("hold_data", o_m_data, held);
      end
      stall = o_m_valid && !ready_d;
      held  = o_m_data;

      if (o_m_valid && first_valid < 0) first_valid = cyc;
      if (o_m_valid && ready_d) begin
        chk("m_data", o_m_data, mem[(base + popped) % RAM_DEPTH]);
        popped++;
        last_pop = cyc;
      end

      if (o_done) begin
        chk("busy_low_at_done", o_busy, 1'b0);
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (done_cyc < 0) begin
        chk("busy_during_cmd", o_busy, 1'b1);
      end else begin
        chk("valid_after_done", o_m_valid, 1'b0);
      end

      if (abort_after > 0 && popped == abort_after) fin = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
    end

    chk("burst_within_budget", fin, 1'b1);
    if (abort_after == 0) begin
      chk("word_count", popped, len);
      chk("done_pulses", done_cnt, 1);
      chk("done_after_last_word", done_cyc, last_pop + 1);
      if (pct >= 100) begin
        chk("first_word_latency", first_valid, rl + 2);
        chk("no_bubbles", last_pop - first_valid, len - 1);
      end
    end
  endtask

  initial begin
    int pct_sel;
    sel = 1'b0; start_d = 1'b0; base_d = '0; len_d = '0; ready_d = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 18'(i);

    // Reset values
    repeat (3) @(posedge clka);
    #1 rstb = 1'b0;
    @(negedge clka);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_m_valid", o_m_valid, 1'b0);
    chk("rst_ram_en", o_ram_en, 1'b0);
    chk("rst_ram_addr", o_ram_addr, 10'd0);
    chk("ram_regce", o_regce, 1'b1);
    chk("rst_l1_busy", bus1.busy, 1'b0);
    chk("rst_l1_m_valid", bus1.m_valid, 1'b0);

    // Full-rate burst and address wrap with mem[i] = i
    run_burst(32'h10, 8, 100, 0, 0);
    run_burst(1022, 4, 100, 0, 0);

    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 18'($urandom);

    // Backpressure at 30% ready duty
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 16, 30, 0, 0);

    // A second start while busy must not disturb the running command
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 12, 100, 3, 0);
    run_burst(1020, 10, 50, 5, 0);

    // Zero-length command
    @(posedge clka); #1;
    start_d = 1'b1; len_d = '0; base_d = 10'($urandom); ready_d = 1'b1;
    @(negedge clka);
    chk("zero_done_not_early", o_done, 1'b0);
    @(posedge clka); #1;
    start_d = 1'b0;
    @(negedge clka);
    chk("zero_done", o_done, 1'b1);
    chk("zero_busy", o_busy, 1'b0);
    chk("zero_ram_en", o_ram_en, 1'b0);
    repeat (3) begin
      @(posedge clka); #1;
      @(negedge clka);
      chk("zero_done_once", o_done, 1'b0);
      chk("zero_no_read", o_ram_en, 1'b0);
      chk("zero_no_valid", o_m_valid, 1'b0);
    end

    // Reset after 3 words of a 10-word burst, then a fresh 2-word command
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 10, 100, 0, 3);
    @(posedge clka); #1;
    rstb = 1'b1;
    @(posedge clka); #1;
    rstb = 1'b0;
    @(negedge clka);
    chk("midrst_m_valid", o_m_valid, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_ram_en", o_ram_en, 1'b0);
    chk("midrst_done", o_done, 1'b0);
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 2, 100, 0, 0);

    // Randomised commands
    for (int n = 0; n < 6; n++) begin
      pct_sel = int'($urandom_range(0, 2));
      run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), int'($urandom_range(1, 24)),
                (pct_sel == 0) ? 30 : ((pct_sel == 1) ? 70 : 100), 0, 0);
    end

    // READ_LATENCY = 1 instance
    @(posedge clka); #1;
    sel = 1'b1;
    run_burst(int'($urandom_range(0, RAM_DEPTH - 1)), 4, 100, 0, 0);
    run_burst(1021, 9, 40, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
